// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus between register-file read, the issue stage and the ALU.
// master is the upstream/consumer side (test harness or pipeline glue); slave is the issue stage.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_ctrl;
  logic [4:0]      rd;
  logic            reg_write;
  logic            branch;
  logic            br_take_on_zero;
  logic            illegal;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd,
           reg_write, branch, br_take_on_zero, illegal
  );

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd,
           reg_write, branch, br_take_on_zero, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes into ALU control + operands, registered output with one-entry skid.
// Optional feature macro: SIGNED_CMP_FIX_EN (signed compares via operand sign-bit inversion).
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_issue_stage_if.slave bus,
  output logic [31:0]      issue_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic [4:0]      rd;
    logic            reg_write;
    logic            branch;
    logic            take_on_zero;
    logic            illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_f;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            unused_rs_fields;

  entry_t dec;
  logic   legal;
  logic   wr;
  logic   signed_cmp;

  entry_t or_q;
  entry_t or_d;
  entry_t sr_q;
  entry_t sr_d;
  logic   or_valid_q;
  logic   or_valid_d;
  logic   sr_valid_q;
  logic   sr_valid_d;
  logic   in_ready_q;
  logic   in_fire;
  logic   out_fire;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign rd_f   = bus.instr[11:7];
  assign imm_i  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s  = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_u  = {bus.instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, bus.instr[24:20]};

  // Register source indices are consumed by register-file read upstream, not here.
  assign unused_rs_fields = ^bus.instr[19:15];

  always_comb begin
    dec        = '0;
    dec.rd     = rd_f;
    legal      = 1'b1;
    wr         = 1'b0;
    signed_cmp = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        dec.a = bus.rs1_data;
        dec.b = bus.rs2_data;
        wr    = 1'b1;
        if (funct7 == F7_BASE) begin
          unique case (funct3)
            3'b000:  dec.ctrl = ALU_ADD;
            3'b001:  dec.ctrl = ALU_SLL;
            3'b010:  begin dec.ctrl = ALU_SLT; signed_cmp = 1'b1; end
            3'b011:  dec.ctrl = ALU_SLT;
            3'b100:  dec.ctrl = ALU_XOR;
            3'b101:  dec.ctrl = ALU_SRL;
            3'b110:  dec.ctrl = ALU_OR;
            default: dec.ctrl = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.ctrl = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.ctrl = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OPIMM: begin
        dec.a = bus.rs1_data;
        dec.b = imm_i;
        wr    = 1'b1;
        unique case (funct3)
          3'b000: dec.ctrl = ALU_ADD;
          3'b010: begin dec.ctrl = ALU_SLT; signed_cmp = 1'b1; end
          3'b011: dec.ctrl = ALU_SLT;
          3'b100: dec.ctrl = ALU_XOR;
          3'b110: dec.ctrl = ALU_OR;
          3'b111: dec.ctrl = ALU_AND;
          3'b001: begin
            dec.b = shamt;
            if (funct7 == F7_BASE) dec.ctrl = ALU_SLL;
            else                   legal    = 1'b0;
          end
          default: begin
            dec.b = shamt;
            if (funct7 == F7_BASE)     dec.ctrl = ALU_SRL;
            else if (funct7 == F7_ALT) dec.ctrl = ALU_SRA;
            else                       legal    = 1'b0;
          end
        endcase
      end
      OPC_LOAD: begin
        dec.ctrl = ALU_ADD;
        dec.a    = bus.rs1_data;
        dec.b    = imm_i;
        wr       = 1'b1;
        legal    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OPC_STORE: begin
        dec.ctrl = ALU_ADD;
        dec.a    = bus.rs1_data;
        dec.b    = imm_s;
        legal    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OPC_LUI: begin
        dec.ctrl = ALU_ADD;
        dec.b    = imm_u;
        wr       = 1'b1;
      end
      OPC_AUIPC: begin
        dec.ctrl = ALU_ADD;
        dec.a    = bus.pc;
        dec.b    = imm_u;
        wr       = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.ctrl = ALU_ADD;
        dec.a    = bus.pc;
        dec.b    = XLEN'(4);
        wr       = 1'b1;
        if (opcode == OPC_JALR && funct3 != 3'b000) legal = 1'b0;
      end
      OPC_BRANCH: begin
        dec.a      = bus.rs1_data;
        dec.b      = bus.rs2_data;
        dec.branch = 1'b1;
        unique case (funct3)
          3'b000:  begin dec.ctrl = ALU_SUB; dec.take_on_zero = 1'b1; end
          3'b001:  dec.ctrl = ALU_SUB;
          3'b100:  begin dec.ctrl = ALU_SLT; signed_cmp = 1'b1; end
          3'b101:  begin dec.ctrl = ALU_SLT; signed_cmp = 1'b1; dec.take_on_zero = 1'b1; end
          3'b110:  dec.ctrl = ALU_SLT;
          3'b111:  begin dec.ctrl = ALU_SLT; dec.take_on_zero = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    // Flipping both sign bits turns the ALU's unsigned compare into a signed one.
`ifdef SIGNED_CMP_FIX_EN
    if (signed_cmp) begin
      dec.a[XLEN-1] = ~dec.a[XLEN-1];
      dec.b[XLEN-1] = ~dec.b[XLEN-1];
    end
`else
    if (signed_cmp) legal = 1'b0;
`endif

    if (!legal) begin
      dec.a            = '0;
      dec.b            = '0;
      dec.ctrl         = ALU_ILL;
      dec.branch       = 1'b0;
      dec.take_on_zero = 1'b0;
      wr               = 1'b0;
    end
    dec.illegal   = !legal;
    dec.reg_write = wr && (rd_f != 5'd0);
  end

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = or_valid_q && bus.out_ready;

  // New entries go straight to OR whenever OR frees up this cycle and nothing older waits in SR.
  always_comb begin
    or_d       = or_q;
    sr_d       = sr_q;
    or_valid_d = or_valid_q;
    sr_valid_d = sr_valid_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (out_fire || !or_valid_q) begin
      if (sr_valid_q) begin
        or_d       = sr_q;
        or_valid_d = 1'b1;
        sr_valid_d = in_fire;
        if (in_fire) sr_d = dec;
      end else begin
        or_valid_d = in_fire;
        if (in_fire) or_d = dec;
      end
    end else if (in_fire) begin
      sr_d       = dec;
      sr_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q        <= '0;
      sr_q        <= '0;
      or_valid_q  <= 1'b0;
      sr_valid_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      issue_count <= '0;
    end else begin
      or_q        <= or_d;
      sr_q        <= sr_d;
      or_valid_q  <= or_valid_d;
      sr_valid_q  <= sr_valid_d;
      in_ready_q  <= !sr_valid_d;
      issue_count <= issue_count + 32'(out_fire);
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = or_valid_q;
  assign bus.alu_a           = or_q.a;
  assign bus.alu_b           = or_q.b;
  assign bus.alu_ctrl        = or_q.ctrl;
  assign bus.rd              = or_q.rd;
  assign bus.reg_write       = or_q.reg_write;
  assign bus.branch          = or_q.branch;
  assign bus.br_take_on_zero = or_q.take_on_zero;
  assign bus.illegal         = or_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: hand-derived expectations queued on input handshake.
// Honours SIGNED_CMP_FIX_EN the same way the design does.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] issue_count;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        tz;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   check_count = 0;
  int   pass_count  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    check_count++;
    if (got === want) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                              input logic [4:0] rd, input logic rw, input logic br,
                              input logic tz, input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.ctrl = ctrl; e.rd = rd; e.rw = rw; e.br = br; e.tz = tz; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mv(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2, input exp_t e);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.e = e;
    return v;
  endfunction

  task automatic buildVectors();
    vecs.push_back(mv(enc_r(7'h00, 2, 1, 3'b000, 3, 7'h33), 0, 5, 7,
                      mk(32'd5, 32'd7, 4'h2, 3, 1, 0, 0, 0)));
    vecs.push_back(mv(enc_r(7'h20, 2, 1, 3'b000, 4, 7'h33), 0, 10, 3,
                      mk(32'd10, 32'd3, 4'h6, 4, 1, 0, 0, 0)));
`ifdef SIGNED_CMP_FIX_EN
    vecs.push_back(mv(enc_r(7'h00, 2, 1, 3'b010, 5, 7'h33), 0, 32'hFFFFFFFF, 1,
                      mk(32'h7FFFFFFF, 32'h80000001, 4'h4, 5, 1, 0, 0, 0)));
`else
    vecs.push_back(mv(enc_r(7'h00, 2, 1, 3'b010, 5, 7'h33), 0, 32'hFFFFFFFF, 1,
                      mk(32'h0, 32'h0, 4'hF, 5, 0, 0, 0, 1)));
`endif
    vecs.push_back(mv(enc_r(7'h00, 2, 1, 3'b011, 6, 7'h33), 0, 32'hFFFFFFFF, 1,
                      mk(32'hFFFFFFFF, 32'h1, 4'h4, 6, 1, 0, 0, 0)));
    vecs.push_back(mv(enc_i(12'h403, 1, 3'b101, 7, 7'h13), 0, 32'h80000000, 0,
                      mk(32'h80000000, 32'd3, 4'hA, 7, 1, 0, 0, 0)));
    vecs.push_back(mv(enc_i(12'hFFF, 1, 3'b000, 8, 7'h13), 0, 32'h10, 0,
                      mk(32'h10, 32'hFFFFFFFF, 4'h2, 8, 1, 0, 0, 0)));
    vecs.push_back(mv(enc_r(7'h00, 2, 1, 3'b001, 0, 7'h63), 0, 9, 9,
                      mk(32'd9, 32'd9, 4'h6, 0, 0, 1, 0, 0)));
    vecs.push_back(mv(enc_r(7'h00, 2, 1, 3'b111, 0, 7'h63), 0, 3, 4,
                      mk(32'd3, 32'd4, 4'h4, 0, 0, 1, 1, 0)));
    vecs.push_back(mv(enc_i(12'h7FC, 1, 3'b010, 9, 7'h03), 0, 32'h100, 0,
                      mk(32'h100, 32'h7FC, 4'h2, 9, 1, 0, 0, 0)));
    vecs.push_back(mv(enc_r(7'h7F, 2, 1, 3'b010, 5'h1C, 7'h23), 0, 32'h200, 32'hDEAD,
                      mk(32'h200, 32'hFFFFFFFC, 4'h2, 5'h1C, 0, 0, 0, 0)));
    vecs.push_back(mv(enc_u(20'h12345, 0, 7'h37), 0, 32'h55, 32'h66,
                      mk(32'h0, 32'h12345000, 4'h2, 0, 0, 0, 0, 0)));
    vecs.push_back(mv(enc_u(20'hABCDE, 10, 7'h17), 32'h1000, 0, 0,
                      mk(32'h1000, 32'hABCDE000, 4'h2, 10, 1, 0, 0, 0)));
    vecs.push_back(mv(enc_u(20'h00000, 1, 7'h6F), 32'h2000, 0, 0,
                      mk(32'h2000, 32'd4, 4'h2, 1, 1, 0, 0, 0)));
    vecs.push_back(mv(32'hFFFFFFFF, 0, 1, 2,
                      mk(32'h0, 32'h0, 4'hF, 5'h1F, 0, 0, 0, 1)));
    vecs.push_back(mv(enc_r(7'h01, 2, 1, 3'b000, 11, 7'h33), 0, 6, 7,
                      mk(32'h0, 32'h0, 4'hF, 11, 0, 0, 0, 1)));
`ifdef SIGNED_CMP_FIX_EN
    vecs.push_back(mv(enc_r(7'h00, 2, 1, 3'b100, 0, 7'h63), 0, 32'hFFFFFFFF, 1,
                      mk(32'h7FFFFFFF, 32'h80000001, 4'h4, 0, 0, 1, 0, 0)));
`else
    vecs.push_back(mv(enc_r(7'h00, 2, 1, 3'b100, 0, 7'h63), 0, 32'hFFFFFFFF, 1,
                      mk(32'h0, 32'h0, 4'hF, 0, 0, 0, 0, 1)));
`endif
    vecs.push_back(mv(enc_r(7'h00, 2, 1, 3'b001, 12, 7'h33), 0, 1, 5,
                      mk(32'd1, 32'd5, 4'h5, 12, 1, 0, 0, 0)));
  endtask

  task automatic setInputs(input vec_t v);
    bus.instr    = v.instr;
    bus.pc       = v.pc;
    bus.rs1_data = v.rs1;
    bus.rs2_data = v.rs2;
  endtask

  task automatic applyStimulus(input vec_t v);
    int   waited;
    logic accepted;
    setInputs(v);
    bus.in_valid = 1'b1;
    accepted     = 1'b0;
    waited       = 0;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(v.e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    checkOutput("accept", 32'(accepted), 32'd1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", exp_q.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("alu_ctrl", 32'(bus.alu_ctrl), 32'(e.ctrl));
        checkOutput("rd", 32'(bus.rd), 32'(e.rd));
        checkOutput("reg_write", 32'(bus.reg_write), 32'(e.rw));
        checkOutput("branch", 32'(bus.branch), 32'(e.br));
        checkOutput("br_take_on_zero", 32'(bus.br_take_on_zero), 32'(e.tz));
        checkOutput("illegal", 32'(bus.illegal), 32'(e.ill));
        if (!e.ill) begin
          checkOutput("alu_a", bus.alu_a, e.a);
          checkOutput("alu_b", bus.alu_b, e.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks made", check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.instr     = '0;
    bus.pc        = '0;
    bus.rs1_data  = '0;
    bus.rs2_data  = '0;
    buildVectors();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_alu_a", bus.alu_a, 32'd0);
    checkOutput("rst_alu_b", bus.alu_b, 32'd0);
    checkOutput("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    checkOutput("rst_rd", 32'(bus.rd), 32'd0);
    checkOutput("rst_flags", 32'({bus.reg_write, bus.branch, bus.br_take_on_zero, bus.illegal}), 32'd0);
    checkOutput("rst_issue_count", issue_count, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] streaming %0d entries with out_ready=1", vecs.size());
    bus.out_ready = 1'b1;
    foreach (vecs[i]) applyStimulus(vecs[i]);
    waitDrain();
    checkOutput("count_stream", issue_count, 32'(vecs.size()));
    base = vecs.size();

    $display("[TB] back-pressure with three back-to-back entries");
    bus.out_ready = 1'b0;
    fork
      begin
        applyStimulus(vecs[0]);
        applyStimulus(vecs[6]);
        applyStimulus(vecs[9]);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("bp_hold_a", bus.alu_a, vecs[0].e.a);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp_hold_b", bus.alu_b, vecs[0].e.b);
        checkOutput("bp_hold_rd", 32'(bus.rd), 32'(vecs[0].e.rd));
        checkOutput("bp_count_held", issue_count, 32'(base));
        bus.out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("count_bp", issue_count, 32'(base + 3));
    base = base + 3;

    $display("[TB] flush with OR and SR full, no output handshake");
    bus.out_ready = 1'b0;
    applyStimulus(vecs[1]);
    applyStimulus(vecs[4]);
    checkOutput("pre_flush_in_ready", 32'(bus.in_ready), 32'd0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("flush_count", issue_count, 32'(base));

    $display("[TB] flush with same-cycle input and output handshakes");
    applyStimulus(vecs[2]);
    setInputs(vecs[5]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush2_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush2_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("flush2_count", issue_count, 32'(base + 1));
    @(posedge clk);
    #1;
    checkOutput("flush2_dropped", 32'(bus.out_valid), 32'd0);

    $display("[TB] asynchronous reset with an entry held");
    bus.out_ready = 1'b0;
    applyStimulus(vecs[7]);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("arst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("arst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("arst_count", issue_count, 32'd0);
    checkOutput("arst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(vecs[10]);
    waitDrain();
    checkOutput("post_rst_count", issue_count, 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage that drives the 4-bit control word and operands of the RV32I ALU. It accepts one instruction per cycle over a valid/ready handshake, decodes opcode/funct3/funct7 into the ALU control encoding, and selects and pre-conditions operands A/B. Results sit in a registered output stage with a one-entry skid buffer, so `in_ready` is a flop output. The block sits between register-file read and the ALU in the execute pipeline.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all buffered entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept; registered.
- `instr`  in  32  instruction word.
- `pc`  in  32  instruction address.
- `rs1_data`, `rs2_data`  in  32  register operands.
- `out_valid`  out  1  issued entry valid.
- `out_ready`  in  1  ALU/EX accepts.
- `alu_a`, `alu_b`  out  32  ALU operands.
- `alu_ctrl`  out  4  ALU control word.
- `rd`  out  5  destination register (`instr[11:7]`).
- `reg_write`  out  1  result is written back.
- `branch`  out  1  conditional branch.
- `br_take_on_zero`  out  1  branch is taken when ALU `zero`=1; otherwise taken when `zero`=0.
- `illegal`  out  1  unsupported encoding.
- `issue_count`  out  32  count of accepted output handshakes.

## Operation
- ALU control encoding: AND 0000, OR 0001, ADD 0010, XOR 0011, SLT(unsigned) 0100, SLL 0101, SUB 0110, SRL 1001, SRA 1010. Illegal entries use 1111, which the ALU evaluates to result 0.
- OP / OP-IMM: the ALU op is selected by funct3 plus `instr[30]` (SUB/SRA). For OP, B=`rs2_data`. For OP-IMM, B is the sign-extended I-immediate; shifts use `instr[24:20]`. SLTU/SLTIU map to 0100 with unmodified operands.
- Signed SLT/SLTI/BLT/BGE: 0100 with bit 31 of both A and B inverted. The unsigned compare then yields the signed result.
- LOAD/STORE: ADD, A=`rs1_data`, B=sign-extended I- or S-immediate. `reg_write`=1 for LOAD only.
- LUI: ADD, A=0, B={`instr[31:12]`,12'b0}.
- AUIPC: ADD, A=`pc`, same B as LUI.
- JAL/JALR: ADD, A=`pc`, B=4, `reg_write`=1; computes the link value.
- BRANCH: `branch`=1, `reg_write`=0.
  - BEQ/BNE: SUB. `br_take_on_zero` is 1 for BEQ, 0 for BNE.
  - BLT/BLTU: SLT. `br_take_on_zero`=0.
  - BGE/BGEU: SLT. `br_take_on_zero`=1.
- Any other opcode or funct3/funct7 combination: `illegal`=1, `reg_write`=0, `branch`=0, `alu_ctrl`=1111. The entry still issues.
- `reg_write` is forced to 0 when `rd`=0.
- Storage: output register (OR) plus skid register (SR).
  - Input handshake fires on `in_valid & in_ready`. Output handshake fires on `out_valid & out_ready`.
  - The decoded entry loads OR when OR is empty or is draining this cycle with SR empty. Otherwise it loads SR.
  - When OR drains and SR is full, SR moves to OR.
  - `in_ready` next = !(SR full next).
- `issue_count` increments by 1 per output handshake and wraps at 2^32−1 → 0.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is presented with `out_valid`=1 after edge N.
- Sustained throughput is 1 entry/cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `in_ready`=1, `alu_a`/`alu_b`=0, `alu_ctrl`=0000, `rd`=0, `reg_write`/`branch`/`br_take_on_zero`/`illegal`=0, `issue_count`=0. SR is empty.
- Reset asserted mid-transfer discards OR and SR immediately (asynchronous).
- `flush`=1 at an edge:
  - OR and SR are emptied and `in_ready`=1 on the next cycle.
  - A same-cycle input handshake is dropped.
  - A same-cycle output handshake still counts.
- Output stability: while `out_valid`=1 and `out_ready`=0, all output fields hold.
- Simultaneous input and output handshakes with SR empty: the new entry replaces OR with no bubble.

## Configuration
- `SIGNED_CMP_FIX_EN` defined: signed compares use the operand sign-bit inversion described above.
- `SIGNED_CMP_FIX_EN` undefined: SLT, SLTI, BLT and BGE decode as illegal. SLTU, SLTIU, BLTU and BGEU are unaffected.

## Test plan
- Reset, then ADD x3,x1,x2 with rs1=5, rs2=7 → next cycle `out_valid`=1, `alu_ctrl`=0010, A=5, B=7, `rd`=3, `reg_write`=1.
- SLT with rs1=0xFFFFFFFF, rs2=1, macro defined → A=0x7FFFFFFF, B=0x80000001, `alu_ctrl`=0100. Macro undefined → `illegal`=1, `alu_ctrl`=1111.
- BNE with rs1=rs2=9 → `alu_ctrl`=0110, `branch`=1, `br_take_on_zero`=0, `reg_write`=0.
- Back-pressure: hold `out_ready`=0 and drive 3 back-to-back valid entries.
  - Entry 1 holds in OR, entry 2 goes to SR, `in_ready`=0 from the following cycle, entry 3 is held upstream.
  - Releasing `out_ready` drains 1, 2, 3 in order with no loss or duplication.
- Assert `flush` with OR and SR full → `out_valid`=0 and `in_ready`=1 next cycle. `issue_count` is unchanged unless an output handshake fired that same cycle.
- LUI x0,0x12345 → A=0, B=0x12345000, `alu_ctrl`=0010, `reg_write`=0.
